// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder and its storage array.
package mem_responder_pkg;

    localparam int MEM_LAT_W = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } memresp_state_e;

    // Replace the bytes of old_w selected by be with the matching bytes of new_w.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word-wide storage: one combinational read port, one byte-enabled write port, no reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [WORDS];

    // Byte-masked write of the addressed word.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= be_merge(mem_q[waddr_i], wdata_i, be_i);
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory target: accepts a word request, waits LATENCY cycles,
// then presents read data or a write acknowledgement with an error flag.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WORDS     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_be_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    mem_req_t             req;
    logic [31:0]          offset;
    logic                 req_err;
    logic [IDX_W-1:0]     req_idx;
    logic                 accept;
    logic                 arr_we;
    logic [IDX_W-1:0]     raddr;
    logic [31:0]          arr_rdata;

    memresp_state_e       state_q;
    logic [MEM_LAT_W-1:0] cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 we_q;
    logic                 err_q;
    logic                 rsp_valid_q;
    mem_rsp_t             rsp_q;
    mem_rsp_t             rsp_d;

    assign req     = '{addr: req_addr_i, we: req_we_i, be: req_be_i, wdata: req_wdata_i};
    assign offset  = req.addr - BASE_ADDR;
    assign req_err = (req.addr[1:0] != 2'b00) | (req.addr < BASE_ADDR) | ((offset >> 2) >= WORDS);
    assign req_idx = offset[IDX_W+1:2];

    assign req_ready_o = (state_q == IDLE) & ~flush_i & ~rst_i;
    assign accept      = req_valid_i & req_ready_o;
    assign arr_we      = accept & req.we & ~req_err;

    // In IDLE the incoming address feeds the read port so LATENCY=0 can respond at the accept edge.
    assign raddr = (state_q == IDLE) ? req_idx : idx_q;

    mem_array #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .waddr_i (req_idx),
        .be_i    (req.be),
        .wdata_i (req.wdata),
        .raddr_i (raddr),
        .rdata_o (arr_rdata)
    );

    // Response captured on entry to RESP: from the live request or the latched one.
    always_comb begin
        logic sel_we;
        logic sel_err;
        sel_we      = (state_q == IDLE) ? req.we  : we_q;
        sel_err     = (state_q == IDLE) ? req_err : err_q;
        rsp_d.err   = sel_err;
        rsp_d.rdata = (sel_we | sel_err) ? '0 : arr_rdata;
    end

    // Control FSM with registered response outputs; reset > flush > handshake/count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        idx_q <= req_idx;
                        we_q  <= req.we;
                        err_q <= req_err;
                        if (LATENCY == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_q       <= rsp_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= MEM_LAT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_q       <= rsp_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_q       <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_q       <= '0;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: three responders (LATENCY 0, 2, 3) exercised one at a time.
module tb_mem_responder;

    localparam int unsigned WORDS = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          NI    = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_ready = 1'b1;
    int          cur = 0;
    int          rdy_mode = 1;

    logic        ready_a [NI];
    logic        valid_a [NI];
    logic        err_a   [NI];
    logic [31:0] rdata_a [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_responder #(
            .WORDS     (WORDS),
            .LATENCY   ((g == 0) ? 0 : g + 1),
            .BASE_ADDR (BASE)
        ) dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .flush_i     (flush),
            .req_valid_i (req_valid && (cur == g)),
            .req_ready_o (ready_a[g]),
            .req_addr_i  (req_addr),
            .req_we_i    (req_we),
            .req_be_i    (req_be),
            .req_wdata_i (req_wdata),
            .rsp_valid_o (valid_a[g]),
            .rsp_ready_i (rsp_ready),
            .rsp_rdata_o (rdata_a[g]),
            .rsp_err_o   (err_a[g])
        );
    end

    logic        c_ready, c_valid, c_err;
    logic [31:0] c_rdata;
    assign c_ready = ready_a[cur];
    assign c_valid = valid_a[cur];
    assign c_err   = err_a[cur];
    assign c_rdata = rdata_a[cur];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [int];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (inst %0d, cycle %0d): got %h expected %h", name, cur, cyc, act, exp);
        end
    endtask

    // Reference: word-addressed store, error rule applied to the byte address.
    function automatic exp_t model(input logic [31:0] a, input logic w,
                                   input logic [3:0] be, input logic [31:0] d);
        exp_t        e;
        logic [31:0] old;
        longint      widx;
        int          key;
        widx  = (longint'(a) - longint'(BASE)) / 4;
        e.err = (a % 4 != 0) || (a < BASE) || (widx >= WORDS);
        key   = cur * int'(WORDS) + int'(widx);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (w) begin
                old = mdl.exists(key) ? mdl[key] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (be[b]) old[8*b +: 8] = d[8*b +: 8];
                mdl[key] = old;
            end else begin
                e.rdata = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
            end
        end
        e.acc = 0;
        return e;
    endfunction

    // rsp_ready driver: 0, 1 or random per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        end
    end

    // Monitor: compares every cycle against the scoreboard front.
    logic prev_valid = 1'b0, prev_flush = 1'b0, prev_rst = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_reset", 32'(c_ready), 32'd0);
            q.delete();
        end else begin
            if (prev_rst) begin
                chk("reset_valid", 32'(c_valid), 32'd0);
                chk("reset_rdata", c_rdata, 32'h0);
                chk("reset_err", 32'(c_err), 32'd0);
            end
            if (prev_flush) chk("valid_after_flush", 32'(c_valid), 32'd0);
            chk("req_ready", 32'(c_ready), 32'((q.size() == 0) && !flush));
            if (c_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(c_valid), 32'd0);
                end else begin
                    chk("rsp_rdata", c_rdata, q[0].rdata);
                    chk("rsp_err", 32'(c_err), 32'(q[0].err));
                    if (!prev_valid) chk("latency", 32'(cyc - q[0].acc), 32'(lat_of(cur) + 1));
                    if (rsp_ready && !flush) void'(q.pop_front());
                end
            end else begin
                chk("idle_rdata", c_rdata, 32'h0);
                chk("idle_err", 32'(c_err), 32'd0);
            end
            if (flush && q.size() != 0) void'(q.pop_front());
        end
        prev_valid = c_valid && !rst;
        prev_flush = flush;
        prev_rst   = rst;
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(posedge clk); #1;
        req_addr = a; req_we = w; req_be = be; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = c_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (got) begin
            e = model(a, w, be, d);
            e.acc = cyc - 1;
            q.push_back(e);
        end else begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("rsp_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_instance();
        logic [31:0] a;
        int          r, w, n;
        rdy_mode = 1;
        // Known contents for the region the random phase uses.
        for (int i = 0; i < 16; i++) issue(BASE + 32'(4 * i), 1'b1, 4'hF, $urandom);
        issue(BASE + 32'(4 * (WORDS - 1)), 1'b1, 4'hF, 32'h0BAD_F00D);
        wait_done();
        // Full write then read-back.
        issue(BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
        issue(BASE + 32'h10, 1'b0, 4'h0, 32'h0);
        // Partial write over a known word; also be=0000 no-op.
        issue(BASE + 32'h20, 1'b1, 4'hF, 32'h1122_3344);
        issue(BASE + 32'h20, 1'b1, 4'b0011, 32'h0000_CAFE);
        issue(BASE + 32'h20, 1'b1, 4'b0000, 32'hFFFF_FFFF);
        issue(BASE + 32'h20, 1'b0, 4'h0, 32'h0);
        wait_done();
        // Backpressure: hold the response 5 cycles, then release.
        rdy_mode = 0;
        issue(BASE + 32'h10, 1'b0, 4'h0, 32'h0);
        n = 0;
        while (!c_valid && n < 50) begin @(negedge clk); n++; end
        idle(5);
        rdy_mode = 1;
        issue(BASE + 32'h20, 1'b0, 4'h0, 32'h0);
        wait_done();
        // Error cases.
        issue(BASE + 32'h12, 1'b0, 4'h0, 32'h0);
        issue(BASE + 32'(4 * WORDS), 1'b1, 4'hF, 32'h5555_AAAA);
        issue(BASE + 32'(4 * (WORDS - 1)), 1'b0, 4'h0, 32'h0);
        issue(BASE - 32'd4, 1'b1, 4'hF, 32'h1234_5678);
        issue(32'hFFFF_FFFC, 1'b0, 4'h0, 32'h0);
        wait_done();
        // Flush one cycle after accept: no response ever.
        issue(BASE + 32'h10, 1'b0, 4'h0, 32'h0);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(8);
        // Flush together with rsp_ready in RESP.
        rdy_mode = 0;
        issue(BASE + 32'h20, 1'b0, 4'h0, 32'h0);
        n = 0;
        while (!c_valid && n < 50) begin @(negedge clk); n++; end
        chk("resp_reached", 32'(c_valid), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1; rdy_mode = 1;
        idle(1);
        flush = 1'b0;
        idle(6);
        // Flush in IDLE blocks acceptance.
        flush = 1'b1; req_valid = 1'b1; req_addr = BASE; req_we = 1'b0;
        @(negedge clk);
        chk("ready_under_flush", 32'(c_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        idle(6);
        // Reset right after an accepted write; the write stays committed.
        issue(BASE + 32'h30, 1'b1, 4'hF, 32'hA5A5_5A5A);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(6);
        issue(BASE + 32'h30, 1'b0, 4'h0, 32'h0);
        wait_done();
        // Randomised traffic with random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 15);
            if (r == 0)      a = BASE + 32'(4 * w) + 32'($urandom_range(1, 3));
            else if (r == 1) a = BASE + 32'(4 * WORDS) + 32'(4 * w);
            else             a = BASE + 32'(4 * w);
            issue(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end
        wait_done();
        rdy_mode = 1;
        idle(3);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
        for (int k = 0; k < NI; k++) begin
            cur = k;
            idle(1);
            run_instance();
        end
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
